// File: rtl/calc_pkg.sv
// Shared key codes, FSM state encoding and key classification helper for calc_sequencer.
package calc_pkg;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
    localparam logic [3:0] KEY_ADD       = 4'd10;
    localparam logic [3:0] KEY_SUB       = 4'd11;
    localparam logic [3:0] KEY_MUL       = 4'd12;
    localparam logic [3:0] KEY_CLR       = 4'd13;
    localparam logic [3:0] KEY_EQ        = 4'd14;

    typedef enum logic [1:0] {
        ST_OP1  = 2'd0,
        ST_OP2  = 2'd1,
        ST_CALC = 2'd2,
        ST_SHOW = 2'd3
    } calc_state_t;

    function automatic logic is_operator(input logic [3:0] code);
        return (code == KEY_ADD) || (code == KEY_SUB) || (code == KEY_MUL);
    endfunction

endpackage

// File: rtl/calc_digit_entry.sv
// Two-digit decimal operand accumulator; digits beyond the second are dropped so value stays <= 99.
module calc_digit_entry (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load_first,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic [6:0] value,
    output logic [1:0] count,
    output logic [6:0] value_next
);

    logic [6:0] value_q, value_d;
    logic [1:0] count_q, count_d;

    // Next operand value: clear, restart with a single digit, or shift in one more digit.
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr) begin
            value_d = 7'd0;
            count_d = 2'd0;
        end else if (digit_valid) begin
            if (load_first) begin
                value_d = {3'b000, digit};
                count_d = 2'd1;
            end else if (count_q != 2'd2) begin
                value_d = (value_q * 7'd10) + {3'b000, digit};
                count_d = count_q + 2'd1;
            end else begin
                value_d = value_q;
                count_d = count_q;
            end
        end else begin
            value_d = value_q;
            count_d = count_q;
        end
    end

    // Operand and digit-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 7'd0;
            count_q <= 2'd0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value      = value_q;
    assign count      = count_q;
    assign value_next = value_d;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad sequencer feeding the combinational calculator; captures its answer for display.
// Optional idle auto-clear is built only when CALC_SEQ_TIMEOUT_EN is defined.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    input  logic [31:0] calc_answer,
    input  logic        calc_signal,
    output logic [6:0]  op_a,
    output logic [6:0]  op_b,
    output logic [3:0]  op_key,
    output logic [31:0] result,
    output logic        result_neg,
    output logic        result_valid,
    output logic [6:0]  entry
);

    calc_state_t state_q;
    logic [3:0]  op_key_q;
    logic [31:0] result_q;
    logic        result_neg_q;
    logic        key_ready_q;
    logic        result_valid_q;
    logic [6:0]  entry_q;

    logic        accept_s, is_digit_s, clear_s, timeout_fire_s;
    logic        a_clr_s, a_load_s, a_dig_s, b_clr_s, b_dig_s;
    logic        op_latch_s, go_calc_s;
    logic [1:0]  a_count_s, b_count_s;
    logic [6:0]  a_next_s, b_next_s;

    // Decode the sampled key into operand and FSM control strobes.
    always_comb begin
        accept_s   = key_valid && (state_q != ST_CALC);
        is_digit_s = (key_code <= KEY_MAX_DIGIT);
        clear_s    = (accept_s && (key_code == KEY_CLR)) || timeout_fire_s;
        a_clr_s    = 1'b0;
        a_load_s   = 1'b0;
        a_dig_s    = 1'b0;
        b_clr_s    = 1'b0;
        b_dig_s    = 1'b0;
        op_latch_s = 1'b0;
        go_calc_s  = 1'b0;
        if (clear_s) begin
            a_clr_s = 1'b1;
            b_clr_s = 1'b1;
        end else if (accept_s) begin
            case (state_q)
                ST_OP1: begin
                    if (is_digit_s) begin
                        a_dig_s = 1'b1;
                    end else if (is_operator(key_code)) begin
                        op_latch_s = 1'b1;
                        b_clr_s    = 1'b1;
                    end else begin
                        op_latch_s = 1'b0;
                    end
                end
                ST_OP2: begin
                    if (is_digit_s) begin
                        b_dig_s = 1'b1;
                    end else if (is_operator(key_code) && (b_count_s == 2'd0)) begin
                        op_latch_s = 1'b1;
                    end else if ((key_code == KEY_EQ) && (b_count_s != 2'd0)) begin
                        go_calc_s = 1'b1;
                    end else begin
                        go_calc_s = 1'b0;
                    end
                end
                ST_SHOW: begin
                    if (is_digit_s) begin
                        a_load_s = 1'b1;
                        a_dig_s  = 1'b1;
                        b_clr_s  = 1'b1;
                    end else begin
                        a_load_s = 1'b0;
                    end
                end
                default: begin
                    a_dig_s = 1'b0;
                end
            endcase
        end else begin
            a_dig_s = 1'b0;
        end
    end

    calc_digit_entry u_entry_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (a_clr_s),
        .load_first  (a_load_s),
        .digit_valid (a_dig_s),
        .digit       (key_code),
        .value       (op_a),
        .count       (a_count_s),
        .value_next  (a_next_s)
    );

    calc_digit_entry u_entry_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (b_clr_s),
        .load_first  (1'b0),
        .digit_valid (b_dig_s),
        .digit       (key_code),
        .value       (op_b),
        .count       (b_count_s),
        .value_next  (b_next_s)
    );

    // Sequencer FSM with operator latch, result capture and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_OP1;
            op_key_q       <= KEY_CLR;
            result_q       <= 32'd0;
            result_neg_q   <= 1'b0;
            key_ready_q    <= 1'b1;
            result_valid_q <= 1'b0;
            entry_q        <= 7'd0;
        end else if (clear_s) begin
            state_q        <= ST_OP1;
            op_key_q       <= KEY_CLR;
            result_q       <= 32'd0;
            result_neg_q   <= 1'b0;
            key_ready_q    <= 1'b1;
            result_valid_q <= 1'b0;
            entry_q        <= 7'd0;
        end else begin
            case (state_q)
                ST_OP1: begin
                    if (op_latch_s) begin
                        state_q  <= ST_OP2;
                        op_key_q <= key_code;
                        entry_q  <= b_next_s;
                    end else begin
                        entry_q  <= a_next_s;
                    end
                end
                ST_OP2: begin
                    entry_q <= b_next_s;
                    if (go_calc_s) begin
                        state_q     <= ST_CALC;
                        key_ready_q <= 1'b0;
                    end else if (op_latch_s) begin
                        op_key_q <= key_code;
                    end else begin
                        state_q <= ST_OP2;
                    end
                end
                ST_CALC: begin
                    // Operands have been stable for the whole cycle, so the answer has settled.
                    state_q        <= ST_SHOW;
                    result_q       <= calc_answer;
                    result_neg_q   <= calc_signal;
                    key_ready_q    <= 1'b1;
                    result_valid_q <= 1'b1;
                    entry_q        <= 7'd0;
                end
                ST_SHOW: begin
                    if (a_load_s) begin
                        state_q        <= ST_OP1;
                        result_valid_q <= 1'b0;
                        entry_q        <= a_next_s;
                    end else begin
                        state_q <= ST_SHOW;
                    end
                end
                default: begin
                    state_q <= ST_OP1;
                end
            endcase
        end
    end

`ifdef CALC_SEQ_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
    logic        cleared_s;

    // Idle counter runs only while there is something left to clear.
    always_comb begin
        cleared_s      = (state_q == ST_OP1) && (op_a == 7'd0) && (a_count_s == 2'd0);
        timeout_fire_s = (idle_q == (TIMEOUT_CYCLES - 32'd1)) && !accept_s && !cleared_s;
        if (accept_s || timeout_fire_s) begin
            idle_d = 32'd0;
        end else if ((state_q != ST_CALC) && !cleared_s) begin
            idle_d = idle_q + 32'd1;
        end else begin
            idle_d = idle_q;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= 32'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout_s;
    assign timeout_fire_s   = 1'b0;
    assign unused_timeout_s = ^{TIMEOUT_CYCLES, a_count_s};
`endif

    assign key_ready    = key_ready_q;
    assign op_key       = op_key_q;
    assign result       = result_q;
    assign result_neg   = result_neg_q;
    assign result_valid = result_valid_q;
    assign entry        = entry_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: directed key sequences plus random keys against a
// behavioural keypad/calculator model; timeout checks run when CALC_SEQ_TIMEOUT_EN is defined.
module tb_calc_sequencer;

    localparam int TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [31:0] calc_answer;
    logic        calc_signal;
    logic [6:0]  op_a, op_b, entry;
    logic [3:0]  op_key;
    logic [31:0] result;
    logic        result_neg, result_valid;

    calc_sequencer #(.TIMEOUT_CYCLES(32'd16)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .calc_answer(calc_answer), .calc_signal(calc_signal),
        .op_a(op_a), .op_b(op_b), .op_key(op_key), .result(result),
        .result_neg(result_neg), .result_valid(result_valid), .entry(entry)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural calculator: {sign, magnitude}.
    function automatic logic [32:0] calc_ref(input int a, input int b, input int k);
        case (k)
            10:      return {1'b0, 32'(a + b)};
            11:      return (a >= b) ? {1'b0, 32'(a - b)} : {1'b1, 32'(b - a)};
            12:      return {1'b0, 32'(a * b)};
            default: return 33'd0;
        endcase
    endfunction

    always_comb {calc_signal, calc_answer} = calc_ref(int'(op_a), int'(op_b), int'(op_key));

    // Reference model: phase 0 = typing first operand, 1 = second, 2 = computing, 3 = showing.
    typedef struct { int res; int neg; int at; } exp_t;
    exp_t sbq[$];
    int m_phase, m_a, m_b, m_na, m_nb, m_key, m_res, m_neg, m_idle;

    task automatic model_clear();
        m_phase = 0; m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
        m_key = 13; m_res = 0; m_neg = 0; m_idle = 0;
    endtask

    task automatic model_reset();
        model_clear();
        sbq.delete();
    endtask

    task automatic model_step(input bit v, input int code);
        bit acc, fire, was_clear;
        int prev_phase;
        logic [32:0] r;
        exp_t e;
        acc        = v && (m_phase != 2);
        prev_phase = m_phase;
        was_clear  = (m_phase == 0) && (m_a == 0) && (m_na == 0);
        fire       = 1'b0;
`ifdef CALC_SEQ_TIMEOUT_EN
        fire = (m_idle == TB_TIMEOUT - 1) && !acc && !was_clear;
`endif
        if (m_phase == 2) begin
            r = calc_ref(m_a, m_b, m_key);
            m_res = int'(r[31:0]); m_neg = int'(r[32]); m_phase = 3;
        end else if ((acc && code == 13) || fire) begin
            model_clear();
        end else if (acc) begin
            if (m_phase == 0) begin
                if (code <= 9) begin
                    if (m_na < 2) begin m_a = m_a * 10 + code; m_na++; end
                end else if (code >= 10 && code <= 12) begin
                    m_key = code; m_b = 0; m_nb = 0; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (code <= 9) begin
                    if (m_nb < 2) begin m_b = m_b * 10 + code; m_nb++; end
                end else if (code >= 10 && code <= 12 && m_nb == 0) begin
                    m_key = code;
                end else if (code == 14 && m_nb > 0) begin
                    m_phase = 2;
                    r = calc_ref(m_a, m_b, m_key);
                    e.res = int'(r[31:0]); e.neg = int'(r[32]); e.at = cyc + 1;
                    sbq.push_back(e);
                end
            end else if (m_phase == 3 && code <= 9) begin
                m_a = code; m_na = 1; m_b = 0; m_nb = 0; m_phase = 0;
            end
        end
        if (acc || fire) m_idle = 0;
        else if (prev_phase != 2 && !was_clear) m_idle++;
    endtask

    task automatic check_all();
        int exp_entry;
        exp_entry = (m_phase == 0) ? m_a : (m_phase == 3) ? 0 : m_b;
        check("op_a", 32'(op_a), 32'(m_a));
        check("op_b", 32'(op_b), 32'(m_b));
        check("op_key", 32'(op_key), 32'(m_key));
        check("key_ready", 32'(key_ready), 32'(m_phase != 2));
        check("result_valid", 32'(result_valid), 32'(m_phase == 3));
        check("entry", 32'(entry), 32'(exp_entry));
        check("result", result, 32'(m_res));
        check("result_neg", 32'(result_neg), 32'(m_neg));
    endtask

    // One clock of stimulus: drive, let the edge sample it, then update model and compare.
    task automatic cycle(input bit v, input int code);
        key_valid = v;
        key_code  = 4'(code);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        model_step(v, code);
        check_all();
    endtask

    task automatic keys(input int seq[]);
        foreach (seq[i]) cycle(1'b1, seq[i]);
    endtask

    // Monitor: pop the scoreboard on every rising result_valid.
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rv_prev <= 1'b0;
        end else begin
            if (result_valid && !rv_prev) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("sb_result", result, 32'(e.res));
                    check("sb_result_neg", 32'(result_neg), 32'(e.neg));
                    check("sb_latency_cycle", 32'(cyc), 32'(e.at));
                end
            end
            rv_prev <= result_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int code;
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        model_reset();
        #22;
        check_all();
        check("reset_op_key", 32'(op_key), 32'd13);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 0);
        check("post_reset_key_ready", 32'(key_ready), 32'd1);

        keys('{1, 2, 10, 3, 4});
        check("tp_op_a_12", 32'(op_a), 32'd12);
        check("tp_op_b_34", 32'(op_b), 32'd34);
        check("tp_op_key_add", 32'(op_key), 32'd10);
        cycle(1'b1, 14);
        cycle(1'b0, 0);
        check("tp_result_46", result, 32'd46);
        check("tp_rv_after_eq", 32'(result_valid), 32'd1);

        keys('{5, 11, 9, 14});
        cycle(1'b0, 0);
        check("tp_result_4", result, 32'd4);
        check("tp_neg_1", 32'(result_neg), 32'd1);
        cycle(1'b1, 7);
        check("tp_show_digit_op_a", 32'(op_a), 32'd7);
        check("tp_show_digit_rv", 32'(result_valid), 32'd0);

        keys('{13, 9, 9, 9});
        check("tp_op_a_99", 32'(op_a), 32'd99);
        keys('{12, 9, 9, 14});
        cycle(1'b0, 0);
        check("tp_result_9801", result, 32'd9801);
        keys('{13, 1, 10, 11});
        check("tp_op_replace", 32'(op_key), 32'd11);

        keys('{13, 4, 10, 13});
        check("tp_clear_op_a", 32'(op_a), 32'd0);
        check("tp_clear_op_key", 32'(op_key), 32'd13);
        keys('{2, 12, 3, 14});
        cycle(1'b1, 3);
        check("tp_calc_drop_op_a", 32'(op_a), 32'd2);
        cycle(1'b0, 0);

        keys('{6, 10, 6, 14});
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("tp_rst_calc_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 0);

`ifdef CALC_SEQ_TIMEOUT_EN
        cycle(1'b1, 7);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) cycle(1'b0, 0);
        check("to_before_expiry", 32'(op_a), 32'd7);
        cycle(1'b0, 0);
        check("to_auto_clear", 32'(op_a), 32'd0);
        cycle(1'b1, 7);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0);
        cycle(1'b1, 3);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0);
        check("to_no_clear", 32'(op_a), 32'd73);
`endif

        for (int i = 0; i < 400; i++) begin
            code = int'($urandom_range(0, 15));
            if (code == 13 && $urandom_range(0, 3) != 0) code = 14;
            cycle(1'($urandom_range(0, 1)), code);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 0);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
